// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake between two requesters, the arbiter and the UART
// transmitter's char/send/busy pins.
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic [7:0] tx_char;
   logic       tx_send;
   logic       tx_busy;

   // Surroundings: the two byte sources and the transmitter.
   modport master (
      output req0_valid, req0_data,
      input  req0_ready,
      output req1_valid, req1_data,
      input  req1_ready,
      input  tx_char, tx_send,
      output tx_busy
   );

   // The arbiter itself.
   modport slave (
      input  req0_valid, req0_data,
      output req0_ready,
      input  req1_valid, req1_data,
      output req1_ready,
      output tx_char, tx_send,
      input  tx_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter between two byte sources.
// One byte is accepted at a time, launched with a single tx_send pulse, and
// tracked through the transmitter's busy window before the next is taken.
module uart_tx_arbiter #(
   parameter int unsigned BUSY_TIMEOUT = 8,   // 1..255 cycles
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus,
   output logic             active,
   output logic             grant_id,
   output logic             err,
   output logic [CNT_W-1:0] sent0_cnt,
   output logic [CNT_W-1:0] sent1_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

   state_t           state_q;
   logic [7:0]       tx_char_q;
   logic             tx_send_q;
   logic             active_q;
   logic             grant_q;
   logic             err_q;
   logic             last_q;
   logic [7:0]       tmo_q;
   logic [CNT_W-1:0] sent0_q;
   logic [CNT_W-1:0] sent1_q;

   logic             cand_valid_d;
   logic             cand_id_d;
   logic             accept_ok_d;

   // Pick the port to serve next: the only valid one, or on a tie the one
   // that was not served last.
   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      cand_valid_d = bus.req0_valid | bus.req1_valid;
      cand_id_d    = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         cand_id_d = ~last_q;
      end
   end

   // Readiness depends only on registered state, tx_busy and the valids,
   // never on the data lines.
   assign accept_ok_d    = (state_q == IDLE) & ~bus.tx_busy;
   assign bus.req0_ready = accept_ok_d & cand_valid_d & ~cand_id_d;
   assign bus.req1_ready = accept_ok_d & cand_valid_d &  cand_id_d;

   // Accept / launch / track-busy sequencer with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge value of every other register.
      if (rst) begin
         state_q   <= IDLE;
         tx_char_q <= 8'h00;
         tx_send_q <= 1'b0;
         active_q  <= 1'b0;
         grant_q   <= 1'b0;
         err_q     <= 1'b0;
         last_q    <= 1'b1;      // port 0 wins the first tie
         tmo_q     <= 8'h00;
         sent0_q   <= '0;
         sent1_q   <= '0;
      end else begin
         tx_send_q <= 1'b0;
         err_q     <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept_ok_d && cand_valid_d) begin
                  tx_char_q <= cand_id_d ? bus.req1_data : bus.req0_data;
                  grant_q   <= cand_id_d;
                  last_q    <= cand_id_d;
                  active_q  <= 1'b1;
                  tx_send_q <= 1'b1;     // high exactly while in LAUNCH
                  state_q   <= LAUNCH;
               end
            end
            LAUNCH: begin
               tmo_q   <= 8'h00;
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state_q <= WAIT_DONE;
               end else if (tmo_q == TMO_LAST) begin
                  // Transmitter never acknowledged: drop the byte uncounted.
                  err_q    <= 1'b1;
                  active_q <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  if (grant_q) begin
                     sent1_q <= sent1_q + CNT_W'(1);
                  end else begin
                     sent0_q <= sent0_q + CNT_W'(1);
                  end
                  active_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx_char = tx_char_q;
   assign bus.tx_send = tx_send_q;
   assign active      = active_q;
   assign grant_id    = grant_q;
   assign err         = err_q;
   assign sent0_cnt   = sent0_q;
   assign sent1_cnt   = sent1_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run against
// a transaction-level model (arbitration rule + frame-end arithmetic).
module tb_uart_tx_arbiter;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if bus ();
   uart_tx_arbiter_if bus_w ();

   logic        active, grant_id, err;
   logic [15:0] sent0_cnt, sent1_cnt;
   logic        active_w, grant_id_w, err_w;
   logic [3:0]  sent0_cnt_w, sent1_cnt_w;

   uart_tx_arbiter #(.BUSY_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .active(active), .grant_id(grant_id),
      .err(err), .sent0_cnt(sent0_cnt), .sent1_cnt(sent1_cnt)
   );

   // Narrow-counter copy fed the same stimulus, used for wrap checks.
   uart_tx_arbiter #(.BUSY_TIMEOUT(TO), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .bus(bus_w), .active(active_w), .grant_id(grant_id_w),
      .err(err_w), .sent0_cnt(sent0_cnt_w), .sent1_cnt(sent1_cnt_w)
   );

   assign bus_w.req0_valid = bus.req0_valid;
   assign bus_w.req0_data  = bus.req0_data;
   assign bus_w.req1_valid = bus.req1_valid;
   assign bus_w.req1_data  = bus.req1_data;
   assign bus_w.tx_busy    = bus.tx_busy;

   // Transmitter stand-in: busy rises the cycle after tx_send and stays high
   // for stub_len cycles; with stub_dead set it ignores tx_send entirely.
   int stub_len  = 4;
   bit stub_dead = 1'b0;
   int busy_left = 0;
   always @(posedge clk) begin
      if (bus.tx_send === 1'b1 && !stub_dead) busy_left <= stub_len;
      else if (busy_left > 0)                 busy_left <= busy_left - 1;
   end
   assign bus.tx_busy = (busy_left != 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; stub_dead = 1'b0;
      for (int i = 0; i < 6000 && bus.tx_busy === 1'b1; i++) @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({bus.tx_send, bus.tx_char, active, grant_id, err} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_outputs: got send/char/act/gnt/err=%h want 000",
                  {bus.tx_send, bus.tx_char, active, grant_id, err});
      end
      vectors++;
      if (sent0_cnt !== 16'd0 || sent1_cnt !== 16'd0 || sent0_cnt_w !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", sent0_cnt, sent1_cnt, sent0_cnt_w);
      end
      rst = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready, active, bus.tx_send} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_idle: got rdy0/rdy1/act/send=%b want 0000",
                  {bus.req0_ready, bus.req1_ready, active, bus.tx_send});
      end
   endtask

   task automatic test_single_byte();
      int act_cycles, extra_sends;
      stub_len = 4340;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_data = 8'h41;
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL single_ready: got rdy0/rdy1=%b want 10", {bus.req0_ready, bus.req1_ready});
      end
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req0_data = 8'hEE;
      #1;
      vectors++;
      if ({bus.tx_send, bus.tx_char, active, grant_id} !== {1'b1, 8'h41, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL single_launch: got send=%b char=%h act=%b gnt=%b want 1 41 1 0",
                  bus.tx_send, bus.tx_char, active, grant_id);
      end
      act_cycles = 0; extra_sends = 0;
      for (int i = 0; i < 6000; i++) begin
         if (active !== 1'b1) break;
         act_cycles++;
         @(negedge clk); #1;
         if (bus.tx_send !== 1'b0) extra_sends++;
         if (bus.req1_ready !== 1'b0) extra_sends++;
      end
      vectors++;
      if (act_cycles != stub_len + 2) begin
         miscompares++;
         $display("FAIL single_active_len: got %0d want %0d", act_cycles, stub_len + 2);
      end
      vectors++;
      if (extra_sends != 0) begin
         miscompares++;
         $display("FAIL single_extra_send: got %0d want 0", extra_sends);
      end
      vectors++;
      if (sent0_cnt !== 16'd1 || sent1_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL single_count: got %0d/%0d want 1/0", sent0_cnt, sent1_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_q[$];
      logic [8:0] hs_q[$];
      logic [8:0] tx_q[$];
      int n0, n1, m0, m1;
      bit last;
      apply_reset();
      stub_len = $urandom_range(2, 12);
      last = 1'b1; m0 = 0; m1 = 0;
      for (int k = 0; k < 4; k++) begin
         last = !last;
         if (last) begin exp_q.push_back({1'b1, 8'hB0 + 8'(m1)}); m1++; end
         else      begin exp_q.push_back({1'b0, 8'hA0 + 8'(m0)}); m0++; end
      end
      n0 = 0; n1 = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         bus.req0_valid = (hs_q.size() < 4);
         bus.req1_valid = (hs_q.size() < 4);
         bus.req0_data  = 8'hA0 + 8'(n0);
         bus.req1_data  = 8'hB0 + 8'(n1);
         #1;
         if (bus.tx_send === 1'b1) tx_q.push_back({grant_id, bus.tx_char});
         if (bus.req0_valid && bus.req0_ready === 1'b1) begin hs_q.push_back({1'b0, bus.req0_data}); n0++; end
         if (bus.req1_valid && bus.req1_ready === 1'b1) begin hs_q.push_back({1'b1, bus.req1_data}); n1++; end
         if (hs_q.size() >= 4 && !bus.req0_valid && active === 1'b0) break;
      end
      vectors++;
      if (hs_q.size() != 4 || tx_q.size() != 4) begin
         miscompares++;
         $display("FAIL b2b_counts: got %0d accepts %0d sends want 4 4", hs_q.size(), tx_q.size());
      end
      for (int k = 0; k < 4; k++) begin
         if (k < hs_q.size() && k < tx_q.size()) begin
            vectors++;
            if (hs_q[k] !== exp_q[k] || tx_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL b2b_order[%0d]: got accept %h sent %h want %h", k, hs_q[k], tx_q[k], exp_q[k]);
            end
         end
      end
      vectors++;
      if (sent0_cnt !== 16'd2 || sent1_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d/%0d want 2/2", sent0_cnt, sent1_cnt);
      end
   endtask

   task automatic test_wait_during_frame();
      int t, first;
      apply_reset();
      stub_len = 30;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_data = 8'h3C;
      #1;
      t = cyc;
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; bus.req1_data = 8'hD2;
      first = -1;
      for (int i = 0; i < 200; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (bus.req1_ready === 1'b1) begin first = cyc; break; end
      end
      vectors++;
      if (first != t + 3 + stub_len) begin
         miscompares++;
         $display("FAIL wait_first_ready: got cycle %0d want %0d", first, t + 3 + stub_len);
      end
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #1;
      vectors++;
      if ({bus.tx_send, grant_id, bus.tx_char} !== {1'b1, 1'b1, 8'hD2}) begin
         miscompares++;
         $display("FAIL wait_grant: got send=%b gnt=%b char=%h want 1 1 d2", bus.tx_send, grant_id, bus.tx_char);
      end
      for (int i = 0; i < 200 && active === 1'b1; i++) @(negedge clk);
      #1;
      vectors++;
      if (sent0_cnt !== 16'd1 || sent1_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL wait_count: got %0d/%0d want 1/1", sent0_cnt, sent1_cnt);
      end
   endtask

   task automatic test_timeout();
      int t, pulses;
      apply_reset();
      stub_dead = 1'b1;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
      #1;
      t = cyc; pulses = 0;
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; bus.req1_data = 8'hC3;
      for (int i = 0; i < 80; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (err === 1'b1) pulses++;
         if (cyc < t + 2 + TO) begin
            vectors++;
            if ({err, active, bus.req1_ready} !== 3'b010) begin
               miscompares++;
               $display("FAIL tmo_wait@%0d: got err/act/rdy1=%b want 010", cyc - t, {err, active, bus.req1_ready});
            end
         end else if (cyc == t + 2 + TO) begin
            vectors++;
            if ({err, active, bus.req1_ready} !== 3'b101) begin
               miscompares++;
               $display("FAIL tmo_fire: got err/act/rdy1=%b want 101", {err, active, bus.req1_ready});
            end
            stub_dead = 1'b0; stub_len = 5;
         end else begin
            bus.req1_valid = 1'b0;
            if (active === 1'b0) break;
         end
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL tmo_pulses: got %0d want 1", pulses);
      end
      vectors++;
      if (sent0_cnt !== 16'd0 || sent1_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL tmo_count: got %0d/%0d want 0/1", sent0_cnt, sent1_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      int t, first;
      stub_dead = 1'b0; stub_len = 40;
      for (int i = 0; i < 200 && (bus.tx_busy === 1'b1 || active === 1'b1); i++) @(negedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
      #1;
      t = cyc;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      vectors++;
      if (active !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_active: got %b want 1", active);
      end
      rst = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req1_data = 8'h88;
      @(negedge clk); #1;
      vectors++;
      if ({bus.tx_send, bus.tx_char, active, grant_id, err, bus.req0_ready, bus.req1_ready} !== 14'h0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got %h want 0",
                  {bus.tx_send, bus.tx_char, active, grant_id, err, bus.req0_ready, bus.req1_ready});
      end
      vectors++;
      if (sent0_cnt !== 16'd0 || sent1_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL rstmid_counters: got %0d/%0d want 0/0", sent0_cnt, sent1_cnt);
      end
      rst = 1'b0;
      first = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin first = cyc; break; end
      end
      vectors++;
      if (first != t + 2 + stub_len || {bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL rstmid_resume: got cycle %0d rdy=%b want cycle %0d rdy=10",
                  first, {bus.req0_ready, bus.req1_ready}, t + 2 + stub_len);
      end
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      #1;
      vectors++;
      if ({grant_id, bus.tx_char} !== {1'b0, 8'h77}) begin
         miscompares++;
         $display("FAIL rstmid_grant: got gnt=%b char=%h want 0 77", grant_id, bus.tx_char);
      end
      for (int i = 0; i < 200 && active === 1'b1; i++) @(negedge clk);
      #1;
      vectors++;
      if (sent0_cnt !== 16'd1 || sent1_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL rstmid_count: got %0d/%0d want 1/0", sent0_cnt, sent1_cnt);
      end
   endtask

   task automatic test_counter_wrap();
      int n;
      apply_reset();
      stub_len = 2;
      n = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         bus.req0_valid = (n < 17);
         bus.req0_data  = 8'($urandom);
         #1;
         if (bus.req0_valid && bus.req0_ready === 1'b1) n++;
         if (n >= 17 && !bus.req0_valid && active === 1'b0) break;
      end
      vectors++;
      if (n != 17) begin
         miscompares++;
         $display("FAIL wrap_accepts: got %0d want 17", n);
      end
      vectors++;
      if (sent0_cnt_w !== 4'(17 % 16) || sent0_cnt !== 16'd17 || sent1_cnt_w !== 4'd0) begin
         miscompares++;
         $display("FAIL wrap_count: got narrow %0d wide %0d p1 %0d want %0d 17 0",
                  sent0_cnt_w, sent0_cnt, sent1_cnt_w, 17 % 16);
      end
   endtask

   task automatic test_random();
      int free_at, t_acc, err_at, cnt0, cnt1;
      bit last, pend, pend_dead, pend_port, cand, v0, v1, exp_r0, exp_r1, exp_act;
      logic [7:0] pend_data;
      apply_reset();
      last = 1'b1; pend = 1'b0; pend_port = 1'b0; pend_data = 8'h00; pend_dead = 1'b0;
      t_acc = -100; err_at = -100; cnt0 = 0; cnt1 = 0; free_at = cyc;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         v0 = ($urandom_range(0, 99) < 50);
         v1 = ($urandom_range(0, 99) < 50);
         bus.req0_valid = v0; bus.req0_data = 8'($urandom);
         bus.req1_valid = v1; bus.req1_data = 8'($urandom);
         #1;
         if (pend && cyc == free_at) begin
            if (!pend_dead) begin
               if (pend_port) cnt1++;
               else           cnt0++;
            end
            pend = 1'b0;
         end
         cand    = (v0 && v1) ? !last : v1;
         exp_r0  = (cyc >= free_at) && (v0 || v1) && !cand;
         exp_r1  = (cyc >= free_at) && (v0 || v1) && cand;
         exp_act = (cyc > t_acc) && (cyc < free_at);
         vectors++;
         if ({bus.req0_ready, bus.req1_ready} !== {exp_r0, exp_r1}) begin
            miscompares++;
            $display("FAIL rnd_ready@%0d: got %b want %b", cyc, {bus.req0_ready, bus.req1_ready}, {exp_r0, exp_r1});
         end
         vectors++;
         if ({bus.tx_send, active, err} !== {cyc == t_acc + 1, exp_act, cyc == err_at}) begin
            miscompares++;
            $display("FAIL rnd_ctrl@%0d: got send/act/err=%b want %b", cyc,
                     {bus.tx_send, active, err}, {cyc == t_acc + 1, exp_act, cyc == err_at});
         end
         if (exp_act) begin
            vectors++;
            if ({grant_id, bus.tx_char} !== {pend_port, pend_data}) begin
               miscompares++;
               $display("FAIL rnd_hold@%0d: got gnt/char=%h want %h", cyc, {grant_id, bus.tx_char}, {pend_port, pend_data});
            end
         end
         vectors++;
         if (sent0_cnt !== 16'(cnt0) || sent1_cnt !== 16'(cnt1) ||
             sent0_cnt_w !== 4'(cnt0) || sent1_cnt_w !== 4'(cnt1)) begin
            miscompares++;
            $display("FAIL rnd_count@%0d: got %0d/%0d narrow %0d/%0d want %0d/%0d", cyc,
                     sent0_cnt, sent1_cnt, sent0_cnt_w, sent1_cnt_w, cnt0, cnt1);
         end
         if (exp_r0 || exp_r1) begin
            pend      = 1'b1;
            pend_port = cand;
            pend_data = cand ? bus.req1_data : bus.req0_data;
            last      = cand;
            t_acc     = cyc;
            pend_dead = ($urandom_range(0, 7) == 0);
            stub_dead = pend_dead;
            stub_len  = $urandom_range(1, 12);
            free_at   = pend_dead ? cyc + 2 + TO : cyc + 3 + stub_len;
            err_at    = pend_dead ? cyc + 2 + TO : -100;
         end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_wait_during_frame();
      test_timeout();
      test_reset_mid_frame();
      test_counter_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one serial transmitter (8N1, 50 MHz clock, divisor 434, 115200 baud) between two byte sources, for example the CPU console port and a debug/monitor port. A round-robin arbiter accepts one byte at a time over a valid/ready handshake. A sequencer then drives the transmitter's char/send inputs and tracks its busy output until the frame ends. The block sits between the requesters and the transmitter's char/send/busy pins.

Parameters:
BUSY_TIMEOUT, 8, max cycles to wait for tx_busy to rise after tx_send before the byte is abandoned (1..255).
CNT_W, 16, width of per-port sent-byte counters.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  port 0 has a byte
req0_data  in  8  port 0 byte
req0_ready  out  1  port 0 byte accepted this cycle when req0_valid & req0_ready
req1_valid  in  1  port 1 has a byte
req1_data  in  8  port 1 byte
req1_ready  out  1  port 1 byte accepted this cycle when req1_valid & req1_ready
tx_char  out  8  byte to transmitter
tx_send  out  1  one-cycle send request to transmitter
tx_busy  in  1  transmitter busy
active  out  1  high from acceptance until frame complete
grant_id  out  1  port whose byte is in flight (valid while active)
err  out  1  one-cycle pulse on busy timeout
sent0_cnt  out  CNT_W  bytes completed from port 0 (wraps)
sent1_cnt  out  CNT_W  bytes completed from port 1 (wraps)

Behaviour:
- Reset: state=IDLE; tx_send=0, tx_char=0, active=0, grant_id=0, err=0, counters=0, last_served=1 (so port 0 wins first tie). Reset mid-frame drops the byte. No abort is sent to the transmitter; the block waits in IDLE for tx_busy=0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: candidate = valid port. If both ports are valid, the candidate is the port != last_served. reqN_ready = (state==IDLE) & !tx_busy & (candidate==N); this is combinational from registered state and the valid inputs. Ready must not depend on reqN_data. On acceptance: tx_char<=data, grant_id<=N, last_served<=N, active<=1, go to LAUNCH. If tx_busy=1 in IDLE, nothing is accepted and both readys are 0.
- LAUNCH: tx_send=1 for exactly this one cycle; timeout counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT: err=1 for one cycle, active<=0, go to IDLE; no counter increment.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0: increment sent{grant_id}_cnt (wraps modulo 2^CNT_W), active<=0, go to IDLE.
- tx_char and grant_id hold stable from acceptance until return to IDLE. tx_send is 0 in all states except LAUNCH.
- Latency: acceptance at cycle T, tx_send at T+1. With the standard transmitter, tx_busy rises at T+2 and the block is in WAIT_DONE at T+3. The earliest next acceptance is the first IDLE cycle after tx_busy falls.
- A requester deasserting valid before acceptance is legal; no byte is taken. Data is sampled only on the valid&ready cycle.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset, then req0_valid=1, data=0x41 at T -> req0_ready=1 at T; tx_send=1 only at T+1 with tx_char=0x41; active=1 until tx_busy falls (~4340 cycles); sent0_cnt=1; req1_ready stays 0.
- Both ports valid continuously (0xA0.. on port 0, 0xB0.. on port 1) -> transmitted order A0,B0,A1,B1; exactly one tx_send per frame; sent0_cnt=sent1_cnt=2 after four frames.
- req1 valid during a port-0 frame -> req1_ready=0 throughout; req1 accepted in the first IDLE cycle after tx_busy=0; grant_id=1.
- tx_busy tied 0 (transmitter stub), BUSY_TIMEOUT=8 -> err pulses once 8 cycles into WAIT_BUSY; counters unchanged; next byte accepted afterward.
- rst asserted in WAIT_DONE while tx_busy=1 -> all outputs at reset values next cycle; no acceptance until tx_busy=0; port 0 wins the next tie.
- CNT_W=4, 17 port-0 bytes -> sent0_cnt wraps to 1.
